vend_dispenser: RTL and testbench
=================================

VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 200, giving the maximum cycles spent waiting for a mechanism done pulse (range 2..255).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of pending-sale queue entries (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1, system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port sell, input, 1, one-cycle sale request pulse from the coin-accepting controller.
REQ-006 The block SHALL have port change, input, 2, the count of 0.5-yuan coins to return (0..3), valid only while sell=1.
REQ-007 The block SHALL have port drink_done, input, 1, a drink-chute sensor pulse.
REQ-008 The block SHALL have port coin_done, input, 1, a coin-hopper sensor pulse.
REQ-009 The block SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-010 The block SHALL have port drink_fire, output, 1, a one-cycle drink motor strobe.
REQ-011 The block SHALL have port coin_fire, output, 1, a one-cycle coin hopper strobe (one coin per strobe).
REQ-012 The block SHALL have port busy, output, 1, high when FSM is not IDLE or the queue is non-empty.
REQ-013 The block SHALL have port full, output, 1, high when the queue holds DEPTH entries.
REQ-014 The block SHALL have port err_to, output, 1, a sticky mechanism-timeout flag.
REQ-015 The block SHALL have port err_ovf, output, 1, a sticky queue-overflow flag.
REQ-016 The block SHALL have port sale_cnt, output, 16, the count of completed sales (see Configuration).

Function
REQ-017 The block SHALL push change into the queue on sell=1 while full=0, and drop it while full=1 (setting err_ovf), even if a pop occurs in the same cycle.
REQ-018 The FSM SHALL have states IDLE, DRINK, WAIT_D, COIN, WAIT_C, with all outputs Moore: drink_fire=(state==DRINK) and coin_fire=(state==COIN).
REQ-019 In IDLE with the queue non-empty, the FSM SHALL pop the head entry, load a 2-bit remaining-coin counter, and go to DRINK next cycle.
REQ-020 DRINK SHALL last exactly one cycle, then go to WAIT_D with the wait counter cleared.
REQ-021 WAIT_D SHALL go on drink_done=1 to COIN if remaining>0, else to IDLE and count one sale.
REQ-022 COIN SHALL last exactly one cycle, then go to WAIT_C with the wait counter cleared.
REQ-023 WAIT_C SHALL, on coin_done=1, decrement remaining and go to COIN if the result is >0, else to IDLE and count one sale.
REQ-024 The 8-bit wait counter SHALL increment each cycle in WAIT_D/WAIT_C; reaching TIMEOUT with no done SHALL set err_to, discard the remaining coins of that entry, count no sale, and go to IDLE.
REQ-025 When done and counter==TIMEOUT coincide, done SHALL take priority.
REQ-026 The FSM SHALL ignore drink_done/coin_done outside their own WAIT state, including in the strobe cycle.
REQ-027 Latency: sell at cycle N into an empty, idle block SHALL give drink_fire high in cycle N+2.
REQ-028 err_clr SHALL clear err_to and err_ovf next edge, with a same-cycle set taking priority over the clear.
REQ-029 Queue pointers SHALL wrap modulo DEPTH, with full/empty from a (log2 DEPTH)+1-bit occupancy count.

Reset
REQ-030 rstn low SHALL force state IDLE, queue empty, the remaining and wait counters to 0, and sale_cnt to 0.
REQ-031 rstn low SHALL force drink_fire, coin_fire, busy, full, err_to, and err_ovf to 0.
REQ-032 Reset mid-dispense SHALL abandon the entry with no further strobes, and the first cycle after release SHALL be IDLE.

Configuration
REQ-033 With macro VEND_DISPENSER_SALE_CNT_EN defined, sale_cnt SHALL be a 16-bit counter incremented once per completed sale and wrapping 65535->0.
REQ-034 With VEND_DISPENSER_SALE_CNT_EN undefined, sale_cnt SHALL be tied to 0 and no counter flops shall exist, with the port list unchanged.

Verification
REQ-035 Bench case 1: sell with change=0 and drink_done 3 cycles after drink_fire -> one drink_fire, no coin_fire, IDLE after done, sale_cnt=1 (macro on).
REQ-036 Bench case 2: sell with change=3 and prompt dones -> one drink_fire then exactly three coin_fire strobes, each following the previous done.
REQ-037 Bench case 3: 5 sell pulses back-to-back with DEPTH=4 and the mechanism stalled -> full=1, 5th dropped, err_ovf=1, 4 sales eventually completed.
REQ-038 Bench case 4: sell with change=2 and no coin_done with TIMEOUT=200 -> err_to=1 at the 200th WAIT_C cycle, no sale counted, next entry proceeds, err_clr clears it.
REQ-039 Bench case 5: rstn pulsed low during WAIT_C -> all outputs 0 immediately, queue empty, no strobe after release.
REQ-040 Bench case 6: drink_done asserted in the DRINK cycle only -> ignored, err_to set after TIMEOUT.

Source files
------------

// File: rtl/vend_dispenser.sv
// ---------------------------------------------------------------------------
// vend_dispenser
//
// Takes completed sales from the coin-accepting controller and drives the
// dispensing mechanism. Each sale waits in a small queue and is then served
// in order: the drink motor is strobed once, followed by one hopper strobe
// per 0.5-yuan coin of change. Every strobe waits for its sensor pulse. A
// mechanism that never answers is abandoned after TIMEOUT cycles, and the
// error is latched in a sticky flag.
//
// Parameters
//   TIMEOUT    maximum cycles spent waiting for a done pulse (2..255)
//   DEPTH      pending-sale queue entries (power of two, 2..8)
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   sell       one-cycle sale request
//   change     number of coins to return with this sale (valid with sell)
//   drink_done drink-chute sensor pulse
//   coin_done  coin-hopper sensor pulse
//   err_clr    clears err_to / err_ovf
//   drink_fire one-cycle drink motor strobe
//   coin_fire  one-cycle coin hopper strobe (one coin per strobe)
//   busy       FSM not idle or queue not empty
//   full       queue holds DEPTH entries
//   err_to     sticky mechanism-timeout flag
//   err_ovf    sticky queue-overflow flag
//   sale_cnt   completed-sale counter
//
// Build option
//   VEND_DISPENSER_SALE_CNT_EN  when defined, sale_cnt is a wrapping 16-bit
//                               completed-sale counter; otherwise it reads 0
//                               and no counter flops are built.
// ---------------------------------------------------------------------------
module vend_dispenser #(
    parameter int TIMEOUT = 200,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sell,
    input  logic [1:0]  change,
    input  logic        drink_done,
    input  logic        coin_done,
    input  logic        err_clr,
    output logic        drink_fire,
    output logic        coin_fire,
    output logic        busy,
    output logic        full,
    output logic        err_to,
    output logic        err_ovf,
    output logic [15:0] sale_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    // The timeout fires in the cycle whose increment would bring the wait
    // counter to TIMEOUT, so a stalled mechanism gets exactly TIMEOUT wait
    // cycles. A done pulse in that same cycle still wins.
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRINK  = 3'd1;
    localparam logic [2:0] WAIT_D = 3'd2;
    localparam logic [2:0] COIN   = 3'd3;
    localparam logic [2:0] WAIT_C = 3'd4;

    // Pending-sale queue: each entry is the coin count of one sale.
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic [2:0]    state_reg, state_next;
    logic [1:0]    rem_reg, rem_next;
    logic [7:0]    wait_reg, wait_next;
    logic          err_to_reg, err_ovf_reg;

    logic          push;
    logic          pop;
    logic          to_hit;
    logic          queue_full;

    assign queue_full = (count_reg == FULL_CNT);

    // A sell arriving while full is dropped even if a pop frees a slot in
    // the same cycle; the controller sees full=1 and must not rely on it.
    assign push = sell && !queue_full;
    assign pop  = (state_reg == IDLE) && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= change;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sequencer. Done pulses are only looked at in their own WAIT state, so
    // a sensor glitch during a strobe cycle has no effect.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        wait_next  = wait_reg;
        to_hit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    rem_next   = mem[rd_ptr_reg];
                    state_next = DRINK;
                end
            end
            DRINK: begin
                wait_next  = '0;
                state_next = WAIT_D;
            end
            WAIT_D: begin
                if (drink_done) begin
                    state_next = (rem_reg != 2'd0) ? COIN : IDLE;
                end else if (wait_reg == WAIT_LAST) begin
                    to_hit     = 1'b1;
                    rem_next   = 2'd0;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            COIN: begin
                wait_next  = '0;
                state_next = WAIT_C;
            end
            WAIT_C: begin
                if (coin_done) begin
                    rem_next   = rem_reg - 2'd1;
                    state_next = (rem_reg != 2'd1) ? COIN : IDLE;
                end else if (wait_reg == WAIT_LAST) begin
                    to_hit     = 1'b1;
                    rem_next   = 2'd0;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            default: begin
                rem_next   = 2'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            rem_reg   <= 2'd0;
            wait_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            wait_reg  <= wait_next;
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr stays set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_to_reg  <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            if (to_hit) begin
                err_to_reg <= 1'b1;
            end else if (err_clr) begin
                err_to_reg <= 1'b0;
            end
            if (sell && queue_full) begin
                err_ovf_reg <= 1'b1;
            end else if (err_clr) begin
                err_ovf_reg <= 1'b0;
            end
        end
    end

`ifdef VEND_DISPENSER_SALE_CNT_EN
    logic [15:0] sale_cnt_reg;
    logic        sale_done;

    // A sale completes on the done pulse that leaves nothing more to pay out.
    assign sale_done = ((state_reg == WAIT_D) && drink_done && (rem_reg == 2'd0)) ||
                       ((state_reg == WAIT_C) && coin_done  && (rem_reg == 2'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sale_cnt_reg <= 16'd0;
        end else if (sale_done) begin
            sale_cnt_reg <= sale_cnt_reg + 16'd1;
        end
    end

    assign sale_cnt = sale_cnt_reg;
`else
    assign sale_cnt = 16'd0;
`endif

    assign drink_fire = (state_reg == DRINK);
    assign coin_fire  = (state_reg == COIN);
    assign busy       = (state_reg != IDLE) || (count_reg != '0);
    assign full       = queue_full;
    assign err_to     = err_to_reg;
    assign err_ovf    = err_ovf_reg;

endmodule

// File: tb/tb_vend_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vend_dispenser
//
// Scenario bench for vend_dispenser (TIMEOUT=200, DEPTH=4). A responder
// process plays the mechanism (done pulses a programmable number of cycles
// after each strobe) and logs every strobe with its cycle number. Each test
// pushes the strobes it expects, with their cycles, when it drives a sale and
// compares them against the log once the sale has played out.
// ---------------------------------------------------------------------------
module tb_vend_dispenser;

    logic        clk;
    logic        rstn;
    logic        sell;
    logic [1:0]  change;
    logic        drink_done;
    logic        coin_done;
    logic        err_clr;
    logic        drink_fire;
    logic        coin_fire;
    logic        busy;
    logic        full;
    logic        err_to;
    logic        err_ovf;
    logic [15:0] sale_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_sales = 0;

    // mechanism model controls
    bit d_en = 0;
    bit c_en = 0;
    bit d_on_fire = 0;
    int d_lat = 1;
    int c_lat = 1;
    int d_pend = 0;
    int c_pend = 0;

    // strobe kinds: 0 = drink, 1 = coin
    int obs_kind[$];
    int obs_cyc[$];
    int exp_kind[$];
    int exp_cyc[$];

    vend_dispenser #(.TIMEOUT(200), .DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sell       (sell),
        .change     (change),
        .drink_done (drink_done),
        .coin_done  (coin_done),
        .err_clr    (err_clr),
        .drink_fire (drink_fire),
        .coin_fire  (coin_fire),
        .busy       (busy),
        .full       (full),
        .err_to     (err_to),
        .err_ovf    (err_ovf),
        .sale_cnt   (sale_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // mechanism responder and strobe logger, active at the falling edge
    initial begin
        drink_done = 1'b0;
        coin_done  = 1'b0;
        forever begin
            @(negedge clk);
            drink_done = 1'b0;
            coin_done  = 1'b0;
            if (d_pend > 0) begin
                d_pend--;
                if (d_pend == 0) drink_done = 1'b1;
            end
            if (c_pend > 0) begin
                c_pend--;
                if (c_pend == 0) coin_done = 1'b1;
            end
            if (drink_fire) begin
                obs_kind.push_back(0);
                obs_cyc.push_back(cyc);
                if (d_on_fire) drink_done = 1'b1;
                else if (d_en) d_pend = d_lat;
            end
            if (coin_fire) begin
                obs_kind.push_back(1);
                obs_cyc.push_back(cyc);
                if (c_en) c_pend = c_lat;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sc_exp();
`ifdef VEND_DISPENSER_SALE_CNT_EN
        return 16'(exp_sales);
`else
        return 16'd0;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_sale(input int s, input int k, input int lat);
        exp_kind.push_back(0);
        exp_cyc.push_back(s);
        for (int j = 1; j <= k; j++) begin
            exp_kind.push_back(1);
            exp_cyc.push_back(s + j * (lat + 1));
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        total++;
        if ({drink_fire, coin_fire, busy, full, err_to, err_ovf} !== 6'b0 || sale_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs: got fires/busy/full/errs=%b sale_cnt=%0d, expected 000000 and 0",
                     {drink_fire, coin_fire, busy, full, err_to, err_ovf}, sale_cnt);
        end
        rstn = 1'b1;
        repeat (2) step();
        total++;
        if (busy !== 1'b0 || drink_fire !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got busy=%b drink_fire=%b, expected 0 0", busy, drink_fire);
        end
        $display("txn reset cyc=%0d", cyc);
    endtask

    task automatic test_drink_only();
        int s, ek, et, ok_k, ok_t;
        d_en = 1; c_en = 1; d_lat = 3; c_lat = 1;
        s = cyc;
        sell = 1'b1; change = 2'd0;
        step();
        sell = 1'b0;
        push_sale(s + 2, 0, 1);
        exp_sales++;
        goto(s + 5);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL c1_busy_waiting: got %b, expected 1", busy);
        end
        step();
        total++;
        if (busy !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c1_idle_after_done: got busy=%b sale_cnt=%0d, expected 0 %0d", busy, sale_cnt, sc_exp());
        end
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c1_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c1_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c1 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    task automatic test_change3();
        int s, ek, et, ok_k, ok_t;
        d_en = 1; c_en = 1; d_lat = 1; c_lat = 1;
        s = cyc;
        sell = 1'b1; change = 2'd3;
        step();
        sell = 1'b0; change = 2'd0;
        push_sale(s + 2, 3, 1);
        exp_sales++;
        goto(s + 10);
        total++;
        if (busy !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c2_done: got busy=%b sale_cnt=%0d, expected 0 %0d", busy, sale_cnt, sc_exp());
        end
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c2_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c2_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c2 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    // A first sale stalls the FSM in WAIT_D until it times out; the burst
    // behind it fills the queue and the fifth sell is dropped.
    task automatic test_overflow();
        int p, t, ek, et, ok_k, ok_t;
        int ch[5] = '{1, 0, 2, 1, 3};
        d_en = 0; c_en = 0; d_lat = 1; c_lat = 1;
        p = cyc;
        sell = 1'b1; change = 2'd0;
        step();
        sell = 1'b0;
        exp_kind.push_back(0); exp_cyc.push_back(p + 2);
        goto(p + 3);
        total++;
        if (err_ovf !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL c3_pre_burst: got err_ovf=%b full=%b, expected 0 0", err_ovf, full);
        end
        for (int i = 0; i < 5; i++) begin
            sell = 1'b1;
            change = 2'(ch[i]);
            err_clr = (i == 4);
            step();
        end
        sell = 1'b0; change = 2'd0; err_clr = 1'b0;
        total++;
        if (full !== 1'b1 || err_ovf !== 1'b1) begin
            bad++;
            $display("FAIL c3_full_ovf: got full=%b err_ovf=%b, expected 1 1", full, err_ovf);
        end
        d_en = 1; c_en = 1;
        goto(p + 203);
        total++;
        if (err_to !== 1'b1) begin
            bad++;
            $display("FAIL c3_prime_timeout: got err_to=%b, expected 1", err_to);
        end
        t = p + 204;
        for (int i = 0; i < 4; i++) begin
            push_sale(t, ch[i], 1);
            t = t + 2 * ch[i] + 3;
        end
        exp_sales += 4;
        goto(t - 1);
        total++;
        if (busy !== 1'b0 || full !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c3_drained: got busy=%b full=%b sale_cnt=%0d, expected 0 0 %0d", busy, full, sale_cnt, sc_exp());
        end
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c3_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c3_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c3 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    task automatic test_timeout();
        int s, ek, et, ok_k, ok_t;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++;
        if (err_to !== 1'b0 || err_ovf !== 1'b0) begin
            bad++;
            $display("FAIL c4_err_clr_pre: got err_to=%b err_ovf=%b, expected 0 0", err_to, err_ovf);
        end
        d_en = 1; c_en = 0; d_lat = 1; c_lat = 1;
        s = cyc;
        sell = 1'b1; change = 2'd2;
        step();
        change = 2'd0;
        step();
        sell = 1'b0;
        exp_kind.push_back(0); exp_cyc.push_back(s + 2);
        exp_kind.push_back(1); exp_cyc.push_back(s + 4);
        exp_kind.push_back(0); exp_cyc.push_back(s + 206);
        goto(s + 204);
        total++;
        if (err_to !== 1'b0) begin
            bad++;
            $display("FAIL c4_err_to_early: got %b at wait cycle 200, expected 0", err_to);
        end
        step();
        total++;
        if (err_to !== 1'b1 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c4_err_to_set: got err_to=%b sale_cnt=%0d, expected 1 %0d", err_to, sale_cnt, sc_exp());
        end
        exp_sales++;
        goto(s + 208);
        total++;
        if (busy !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c4_next_entry: got busy=%b sale_cnt=%0d, expected 0 %0d", busy, sale_cnt, sc_exp());
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++;
        if (err_to !== 1'b0) begin
            bad++;
            $display("FAIL c4_err_clr: got err_to=%b, expected 0", err_to);
        end
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c4_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c4_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c4 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid();
        int s, ek, et, ok_k, ok_t;
        d_en = 1; c_en = 0; d_lat = 1; c_lat = 1;
        s = cyc;
        sell = 1'b1; change = 2'd3;
        step();
        change = 2'd1;
        step();
        sell = 1'b0; change = 2'd0;
        exp_kind.push_back(0); exp_cyc.push_back(s + 2);
        exp_kind.push_back(1); exp_cyc.push_back(s + 4);
        goto(s + 6);
        rstn = 1'b0;
        #1;
        exp_sales = 0;
        total++;
        if ({drink_fire, coin_fire, busy, full, err_to, err_ovf} !== 6'b0 || sale_cnt !== 16'd0) begin
            bad++;
            $display("FAIL c5_reset_outputs: got fires/busy/full/errs=%b sale_cnt=%0d, expected 000000 and 0",
                     {drink_fire, coin_fire, busy, full, err_to, err_ovf}, sale_cnt);
        end
        repeat (2) step();
        rstn = 1'b1;
        repeat (30) step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL c5_queue_empty: got busy=%b after release, expected 0", busy);
        end
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c5_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c5_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c5 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    task automatic test_done_in_strobe();
        int s, ek, et, ok_k, ok_t;
        d_en = 0; c_en = 1; d_on_fire = 1;
        s = cyc;
        sell = 1'b1; change = 2'd1;
        step();
        sell = 1'b0; change = 2'd0;
        exp_kind.push_back(0); exp_cyc.push_back(s + 2);
        goto(s + 202);
        total++;
        if (err_to !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL c6_waiting: got err_to=%b busy=%b, expected 0 1", err_to, busy);
        end
        step();
        total++;
        if (err_to !== 1'b1 || busy !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c6_timeout: got err_to=%b busy=%b sale_cnt=%0d, expected 1 0 %0d", err_to, busy, sale_cnt, sc_exp());
        end
        d_on_fire = 0;
        step();
        total++;
        if (obs_kind.size() != exp_kind.size()) begin
            bad++;
            $display("FAIL c6_strobe_count: got %0d, expected %0d", obs_kind.size(), exp_kind.size());
        end
        while (exp_kind.size() > 0 && obs_kind.size() > 0) begin
            ek = exp_kind.pop_front(); et = exp_cyc.pop_front();
            ok_k = obs_kind.pop_front(); ok_t = obs_cyc.pop_front();
            total++;
            if (ok_k !== ek || ok_t !== et) begin
                bad++;
                $display("FAIL c6_strobe: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", ok_k, ok_t, ek, et);
            end else $display("txn c6 kind=%0d cyc=%0d", ok_k, ok_t);
        end
        exp_kind.delete(); exp_cyc.delete(); obs_kind.delete(); obs_cyc.delete();
    endtask

    // done arriving in the last allowed wait cycle beats the timeout
    task automatic test_done_at_limit();
        int s;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        d_en = 1; c_en = 1; d_lat = 200;
        s = cyc;
        sell = 1'b1; change = 2'd0;
        step();
        sell = 1'b0;
        exp_sales++;
        goto(s + 203);
        total++;
        if (err_to !== 1'b0 || busy !== 1'b0 || sale_cnt !== sc_exp()) begin
            bad++;
            $display("FAIL c7_done_priority: got err_to=%b busy=%b sale_cnt=%0d, expected 0 0 %0d", err_to, busy, sale_cnt, sc_exp());
        end else $display("txn c7 done at limit cyc=%0d", cyc);
        obs_kind.delete(); obs_cyc.delete();
        d_lat = 1;
    endtask

    initial begin
        rstn = 1'b0;
        sell = 1'b0;
        change = 2'd0;
        err_clr = 1'b0;
        test_reset();
        test_drink_only();
        test_change3();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_done_in_strobe();
        test_done_at_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
